// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and loader state encoding
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int INSTR_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2, FINISH = 2'd3} loader_state_e;
  function automatic logic count_ok(input logic [15:0] count, input int unsigned max_words);
    return count != 16'd0 && 32'(count) <= max_words;
  endfunction
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte stream in, memory write port and status out
interface instruction_loader_if;
  import riscv_pkg::*;
  logic START;
  logic [15:0] WORD_COUNT;
  logic [7:0] BYTE_IN;
  logic BYTE_VALID;
  logic BYTE_READY;
  logic WR_EN;
  logic [XLEN-1:0] WR_ADDR;
  logic [INSTR_WIDTH-1:0] WR_DATA;
  logic BUSY;
  logic DONE;
  logic ERROR;
  modport master (output START, WORD_COUNT, BYTE_IN, BYTE_VALID,
                  input BYTE_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERROR);
  modport slave (input START, WORD_COUNT, BYTE_IN, BYTE_VALID,
                 output BYTE_READY, WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERROR);
endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// byte_assembler: little-endian byte insert register with a 2-bit lane counter
module byte_assembler
  import riscv_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CLEAR,
  input  logic [7:0]             BYTE_IN,
  input  logic                   ACCEPT,
  output logic [INSTR_WIDTH-1:0] WORD,
  output logic                   FULL
);
  logic [1:0] k;
  always_ff @(posedge CLK)
    if (RESET) begin
      k <= 2'd0;
      WORD <= '0;
    end else if (CLEAR) begin
      k <= 2'd0;
    end else if (ACCEPT) begin
      WORD[{k, 3'b000} +: 8] <= BYTE_IN;
      k <= k + 2'd1;
    end
  assign FULL = k == 2'd3;
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a byte stream into 32-bit words and writes them to consecutive addresses
module instruction_loader
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = 64'h0,
  parameter int unsigned     MAX_WORDS = 256
) (
  input logic CLK,
  input logic RESET,
  instruction_loader_if.slave bus
);
  loader_state_e state;
  logic [15:0] count, index;
  logic full, accept, clear;
  assign accept = bus.BYTE_VALID & bus.BYTE_READY;
  assign clear = state == IDLE && bus.START;
  byte_assembler u_asm (
    .CLK(CLK), .RESET(RESET), .CLEAR(clear), .BYTE_IN(bus.BYTE_IN),
    .ACCEPT(accept), .WORD(bus.WR_DATA), .FULL(full)
  );
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      count <= '0;
      index <= '0;
      bus.BYTE_READY <= 1'b0;
      bus.WR_EN <= 1'b0;
      bus.WR_ADDR <= '0;
      bus.BUSY <= 1'b0;
      bus.DONE <= 1'b0;
      bus.ERROR <= 1'b0;
    end else begin
      bus.ERROR <= 1'b0;
      bus.WR_EN <= 1'b0;
      bus.DONE <= 1'b0;
      case (state)
        IDLE:
          if (bus.START) begin
            if (count_ok(bus.WORD_COUNT, MAX_WORDS)) begin
              count <= bus.WORD_COUNT;
              index <= '0;
              state <= COLLECT;
              bus.BYTE_READY <= 1'b1;
              bus.BUSY <= 1'b1;
            end else bus.ERROR <= 1'b1;
          end
        COLLECT:
          if (accept && full) begin
            state <= WRITE;
            bus.BYTE_READY <= 1'b0;
            bus.WR_EN <= 1'b1;
            bus.WR_ADDR <= BASE_ADDR + XLEN'({index, 2'b00});
          end
        WRITE: begin
          index <= index + 16'd1;
          state <= index + 16'd1 == count ? FINISH : COLLECT;
          bus.DONE <= index + 16'd1 == count;
          bus.BYTE_READY <= index + 16'd1 != count;
        end
        FINISH: begin
          state <= IDLE;
          bus.BUSY <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized scoreboard bench; stimulus queues expectations, a negedge monitor checks them
module tb_instruction_loader;
  import riscv_pkg::*;
  localparam logic [63:0] BASE = 64'h0;
  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int cyc;
    int gap;
  } wr_t;
  logic clk = 1'b0, rst = 1'b1;
  instruction_loader_if bus ();
  instruction_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  wr_t wr_q[$];
  int done_q[$], err_q[$];
  logic [7:0] bq[$];
  int errors = 0, checks = 0, prev_wr = 0;
  logic chk_zero = 0, tmo = 0, chk_end = 0, busy_chk = 0, busy_exp = 0;

  always @(negedge clk) begin
    wr_t e;
    #1;
    if (bus.WR_EN) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected addr=%h data=%h at cycle %0d", bus.WR_ADDR, bus.WR_DATA, cyc);
      end else begin
        e = wr_q.pop_front();
        if (bus.WR_ADDR !== e.addr || bus.WR_DATA !== e.data || cyc != e.cyc || (e.gap != 0 && cyc - prev_wr != e.gap)) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h cycle=%0d gap=%0d, want addr=%h data=%h cycle=%0d gap=%0d",
                   bus.WR_ADDR, bus.WR_DATA, cyc, cyc - prev_wr, e.addr, e.data, e.cyc, e.gap);
        end
      end
      prev_wr = cyc;
    end
    if (bus.DONE) begin
      checks++;
      if (done_q.size() == 0 || done_q[0] != cyc) begin
        errors++;
        $display("FAIL done: pulse at cycle %0d, want %0d", cyc, done_q.size() ? done_q[0] : -1);
      end
      if (done_q.size()) void'(done_q.pop_front());
    end
    if (bus.ERROR) begin
      checks++;
      if (err_q.size() == 0 || err_q[0] != cyc || bus.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL error: pulse at cycle %0d busy=%b, want cycle %0d busy=0", cyc, bus.BUSY, err_q.size() ? err_q[0] : -1);
      end
      if (err_q.size()) void'(err_q.pop_front());
    end
    if (chk_zero) begin
      checks++;
      if ({bus.BYTE_READY, bus.WR_EN, bus.BUSY, bus.DONE, bus.ERROR, bus.WR_ADDR, bus.WR_DATA} !== '0) begin
        errors++;
        $display("FAIL reset_state: rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h, want all 0",
                 bus.BYTE_READY, bus.WR_EN, bus.BUSY, bus.DONE, bus.ERROR, bus.WR_ADDR, bus.WR_DATA);
      end
    end
    if (busy_chk) begin
      checks++;
      if (bus.BUSY !== busy_exp || bus.BYTE_READY !== busy_exp) begin
        errors++;
        $display("FAIL busy: busy=%b ready=%b, want %b", bus.BUSY, bus.BYTE_READY, busy_exp);
      end
    end
    if (tmo) begin
      checks++;
      errors++;
      $display("FAIL timeout: BYTE_READY never rose, got 0 want 1 at cycle %0d", cyc);
    end
    if (chk_end) begin
      checks++;
      if (wr_q.size() || done_q.size() || err_q.size()) begin
        errors++;
        $display("FAIL drain: pending writes=%0d dones=%0d errors=%0d, want 0", wr_q.size(), done_q.size(), err_q.size());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    bq.push_back(a);
    bq.push_back(b);
    bq.push_back(c);
    bq.push_back(d);
  endtask

  task automatic start(input logic [15:0] n);
    bus.START = 1'b1;
    bus.WORD_COUNT = n;
    if (n == 0 || n > 256) err_q.push_back(cyc + 1);
    tick();
    bus.START = 1'b0;
    busy_exp = n != 0 && n <= 256;
    busy_chk = 1'b1;
    tick();
    busy_chk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b[4], input int idx, input bit last, input bit gaps, input int gap);
    int c;
    for (int k = 0; k < 4; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_IN = 8'($urandom);
        tick();
      end
      bus.BYTE_VALID = 1'b1;
      bus.BYTE_IN = b[k];
      c = 0;
      while (!bus.BYTE_READY && c < 40) begin
        tick();
        c++;
      end
      if (c == 40) begin
        tmo = 1'b1;
        tick();
        tmo = 1'b0;
        bus.BYTE_VALID = 1'b0;
        return;
      end
      if (k == 3) begin
        wr_q.push_back('{BASE + 64'(idx) * 64'd4, {b[3], b[2], b[1], b[0]}, cyc + 1, gap});
        if (last) done_q.push_back(cyc + 2);
      end
      tick();
    end
    bus.BYTE_VALID = 1'b0;
  endtask

  task automatic load(input bit gaps, input int gap, input bit poke);
    int n = bq.size() / 4;
    logic [7:0] w[4];
    start(16'(n));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) w[k] = bq[4 * i + k];
      if (poke && i == 1) begin
        tick();
        bus.START = 1'b1;
        bus.WORD_COUNT = 16'd1;
        tick();
        bus.START = 1'b0;
      end
      send_word(w, i, i == n - 1, gaps, i > 0 ? gap : 0);
    end
    bq.delete();
    repeat (3) tick();
  endtask

  initial begin
    bus.START = 1'b0;
    bus.WORD_COUNT = '0;
    bus.BYTE_IN = '0;
    bus.BYTE_VALID = 1'b0;
    tick();
    chk_zero = 1'b1;
    rst = 1'b0;
    tick();
    chk_zero = 1'b0;
    add(8'h13, 8'h00, 8'h00, 8'h00);
    load(0, 0, 0);
    add(8'hB3, 8'h02, 8'h50, 8'h00);
    add(8'h93, 8'h02, 8'h10, 8'h00);
    add(8'h33, 8'h03, 8'h53, 8'h00);
    load(0, 5, 0);
    add(8'hB3, 8'h02, 8'h50, 8'h00);
    add(8'h93, 8'h02, 8'h10, 8'h00);
    load(1, 0, 0);
    start(16'd0);
    start(16'd257);
    repeat (2) tick();
    start(16'd1);
    for (int k = 0; k < 2; k++) begin
      bus.BYTE_VALID = 1'b1;
      bus.BYTE_IN = 8'hA5 + 8'(k);
      tick();
    end
    bus.BYTE_VALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero = 1'b1;
    tick();
    chk_zero = 1'b0;
    add(8'h11, 8'h22, 8'h33, 8'h44);
    load(0, 0, 0);
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    load(0, 0, 1);
    repeat (10) begin
      if ($urandom_range(0, 3) == 0) begin
        start($urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(257, 65535)));
        tick();
      end else begin
        repeat ($urandom_range(1, 5)) add(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        load(1'($urandom), 0, 0);
      end
    end
    repeat (5) tick();
    chk_end = 1'b1;
    tick();
    chk_end = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that fills the instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each complete word is written to consecutive byte addresses starting at a base address. It is the write-side counterpart of `instruction_memory`, which only serves reads, and it sits between the debug/boot byte source and the memory's write port.

## Interface
Parameters:
- `BASE_ADDR`, 64'h0, byte address of the first instruction written.
- `MAX_WORDS`, 256, largest legal word count per load.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `WORD_COUNT`  in  16  number of words to load; sampled with `START`.
- `BYTE_IN`  in  8  stream byte.
- `BYTE_VALID`  in  1  `BYTE_IN` is valid.
- `BYTE_READY`  out  1  loader can accept a byte this cycle.
- `WR_EN`  out  1  memory write strobe, one cycle per word.
- `WR_ADDR`  out  64  byte address of the word being written.
- `WR_DATA`  out  32  assembled instruction word.
- `BUSY`  out  1  high in every state except IDLE.
- `DONE`  out  1  one-cycle pulse after the last write.
- `ERROR`  out  1  one-cycle pulse when `START` carries an illegal `WORD_COUNT`.

## Operation
- States: IDLE, COLLECT, WRITE, FINISH. Two-bit encoding, IDLE = 0.
- IDLE:
  - `START`=1 with 1 ≤ `WORD_COUNT` ≤ `MAX_WORDS`: latch the count, clear the word index and byte counter, go to COLLECT.
  - `START`=1 with `WORD_COUNT`=0 or `WORD_COUNT` > `MAX_WORDS`: pulse `ERROR` the next cycle and stay in IDLE.
- COLLECT:
  - `BYTE_READY`=1.
  - A byte is accepted on any cycle with `BYTE_VALID` & `BYTE_READY`.
  - The byte counter k (0..3) places the byte at `WR_DATA`[8k+7:8k], so the first byte is the LSB.
  - Accepting the 4th byte moves the FSM to WRITE.
  - `BYTE_VALID`=0 stalls indefinitely, with no timeout.
- WRITE:
  - `WR_EN`=1 for exactly one cycle and `BYTE_READY`=0.
  - `WR_ADDR` = `BASE_ADDR` + 4·index, computed in 64-bit arithmetic; wrap-around modulo 2^64 is allowed.
  - The index then increments. If index+1 = count, go to FINISH; otherwise go to COLLECT with the byte counter at 0.
- FINISH: `DONE`=1 for one cycle, then IDLE.
- `START` outside IDLE is ignored.
- Bytes presented outside COLLECT are not accepted, because `BYTE_READY`=0.
- Reset mid-operation:
  - Return to IDLE and discard any partial word.
  - No write is issued in the reset cycle or after it.
- Reset values:
  - State IDLE.
  - `BYTE_READY`, `WR_EN`, `BUSY`, `DONE`, `ERROR` = 0.
  - `WR_ADDR`, `WR_DATA` = 0.
  - Internal counters = 0.

## Timing
- All outputs are registered; none is combinational from inputs.
- `START` accepted at edge t: `BUSY`=1 and `BYTE_READY`=1 from cycle t+1.
- 4th byte accepted at edge t: `WR_EN`=1 in cycle t+1, with `WR_ADDR`/`WR_DATA` stable that cycle. `BYTE_READY` returns to 1 in cycle t+2 if words remain.
- Throughput is one word per 5 cycles with back-to-back bytes.
- Last `WR_EN` in cycle t: `DONE`=1 in cycle t+1, `BUSY`=0 from cycle t+2.
- Illegal `START` at edge t: `ERROR`=1 in cycle t+1 only, and `BUSY` stays 0.
- `RESET` sampled high at edge t: all outputs take their reset values in cycle t+1.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`=64 and `INSTR_WIDTH`=32.
  - Loader state typedef/localparams; the memory interface also uses `XLEN` and `INSTR_WIDTH`.
- Sub-module `byte_assembler`:
  - A 4-byte little-endian shift/insert register with a 2-bit counter.
  - Signals: `CLK`, `RESET`, `CLEAR`, `BYTE_IN`, `ACCEPT`; outputs `WORD`, `FULL`.
  - `instruction_loader` owns the FSM, index counter and address generation.

## Test plan
- Reset then `START` with `WORD_COUNT`=1, bytes 13,00,00,00 back-to-back -> one `WR_EN` with `WR_ADDR`=0 and `WR_DATA`=32'h00000013, then `DONE` the following cycle.
- `WORD_COUNT`=3 with bytes B3,02,50,00 / 93,02,10,00 / 33,03,53,00 -> writes 32'h005002B3@0, 32'h00100293@4, 32'h00530333@8, each exactly 5 cycles apart.
- `BYTE_VALID` toggled with random gaps during a 2-word load -> identical data/addresses to the gapless run, and no `WR_EN` before the 4th byte.
- `START` with `WORD_COUNT`=0, then with 257 -> a single `ERROR` pulse each, `BUSY` stays 0, and no `WR_EN`.
- `RESET` asserted after 2 bytes of word 1 -> no `WR_EN`, and outputs are 0 the next cycle. A new load with `WORD_COUNT`=1 then writes at `BASE_ADDR` with only the new bytes.
- `START` pulsed during COLLECT -> ignored; the count and index are unchanged and the load completes normally.
